// File: rtl/sha256_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sha256_round_ctrl
// Brief    : Sequencing FSM for the SHA-256 compression core. Drives the
//            external 7-bit round counter (load/enable), issues init/round/
//            final strobes to the datapath and repeats the round sequence
//            PASSES times per job. Start and done use valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_round_ctrl #(
  parameter  int ROUNDS = 64,
  parameter  int PASSES = 2,
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_valid,
  output logic          start_ready,
  output logic          cnt_ld,
  output logic [6:0]    cnt_ld_data,
  output logic          cnt_en,
  input  logic [6:0]    cnt_value,
  output logic          core_init,
  output logic          round_en,
  output logic          core_final,
  output logic [PW-1:0] pass_idx,
  output logic          busy,
  output logic          done_valid,
  input  logic          done_ready,
  input  logic          abort
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [6:0]    c_last_round = 7'(ROUNDS - 1);
  localparam logic [PW-1:0] c_last_pass  = PW'(PASSES - 1);

  state_t        r_state;
  logic [PW-1:0] r_pass;
  state_t        w_nstate;
  logic [PW-1:0] w_npass;

  // The counter always restarts from zero; INIT loads it before every pass.
  assign cnt_ld_data = 7'd0;
  assign pass_idx    = r_pass;

  // Next-state and next-pass selection; abort overrides every other exit.
  always_comb begin
    w_nstate = r_state;
    w_npass  = r_pass;
    if ((r_state != S_IDLE) && abort) begin
      w_nstate = S_IDLE;
      w_npass  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            w_nstate = S_INIT;
            w_npass  = '0;
          end
        end
        S_INIT:  w_nstate = S_ROUND;
        S_ROUND: begin
          // >= rather than == so a corrupted count still leaves ROUND.
          if (cnt_value >= c_last_round) begin
            w_nstate = S_FINAL;
          end
        end
        S_FINAL: begin
          if (r_pass == c_last_pass) begin
            w_nstate = S_DONE;
          end else begin
            w_npass  = r_pass + 1'b1;
            w_nstate = S_INIT;
          end
        end
        S_DONE: begin
          if (done_ready) begin
            w_nstate = S_IDLE;
            w_npass  = '0;
          end
        end
        default: begin
          w_nstate = S_IDLE;
          w_npass  = '0;
        end
      endcase
    end
  end

  // State, pass and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pass      <= '0;
      start_ready <= 1'b1;
      cnt_ld      <= 1'b0;
      cnt_en      <= 1'b0;
      core_init   <= 1'b0;
      round_en    <= 1'b0;
      core_final  <= 1'b0;
      busy        <= 1'b0;
      done_valid  <= 1'b0;
    end else begin
      r_state     <= w_nstate;
      r_pass      <= w_npass;
      start_ready <= (w_nstate == S_IDLE);
      cnt_ld      <= (w_nstate == S_INIT);
      core_init   <= (w_nstate == S_INIT);
      cnt_en      <= (w_nstate == S_ROUND);
      round_en    <= (w_nstate == S_ROUND);
      core_final  <= (w_nstate == S_FINAL);
      busy        <= (w_nstate != S_IDLE);
      done_valid  <= (w_nstate == S_DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_round_ctrl
// Brief    : Self-checking bench for sha256_round_ctrl with an attached
//            round-counter model and a cycle-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_round_ctrl;

  localparam int ROUNDS = 64;
  localparam int PASSES = 2;
  localparam int PW     = 1;
  localparam int PER    = ROUNDS + 2;
  localparam int TOTAL  = PASSES * PER;
  localparam int LAT    = 1 + TOTAL;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_valid, start_ready;
  logic          cnt_ld, cnt_en;
  logic [6:0]    cnt_ld_data, cnt_value;
  logic          core_init, round_en, core_final;
  logic [PW-1:0] pass_idx;
  logic          busy, done_valid, done_ready, abort;

  logic [6:0]    cnt_q;
  logic          force_en;
  logic [6:0]    force_val;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_k;       // -1 = idle, else cycles elapsed since INIT of pass 0
  bit m_chk;

  always #5 clk = ~clk;

  // Round counter as seen by the controller.
  always @(posedge clk or posedge rst) begin
    if (rst)         cnt_q <= 7'd0;
    else if (cnt_ld) cnt_q <= cnt_ld_data;
    else if (cnt_en) cnt_q <= cnt_q + 7'd1;
  end
  assign cnt_value = force_en ? force_val : cnt_q;

  sha256_round_ctrl #(.ROUNDS(ROUNDS), .PASSES(PASSES)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .cnt_ld(cnt_ld), .cnt_ld_data(cnt_ld_data), .cnt_en(cnt_en),
    .cnt_value(cnt_value),
    .core_init(core_init), .round_en(round_en), .core_final(core_final),
    .pass_idx(pass_idx), .busy(busy),
    .done_valid(done_valid), .done_ready(done_ready), .abort(abort)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the job's cycle position: each pass is one INIT,
  // ROUNDS round cycles and one FINAL; after all passes the digest waits.
  task automatic check_model();
    bit sr = 0, ld = 0, en = 0, ini = 0, rnd = 0, fin = 0, bz = 0, dv = 0;
    int pi = 0, pos = 0;
    logic [15:0] e, a;
    if (m_k < 0) begin
      sr = 1;
    end else if (m_k < TOTAL) begin
      bz  = 1;
      pi  = m_k / PER;
      pos = m_k % PER;
      ini = (pos == 0);
      ld  = ini;
      rnd = (pos >= 1) && (pos <= ROUNDS);
      en  = rnd;
      fin = (pos == ROUNDS + 1);
    end else begin
      bz = 1;
      dv = 1;
      pi = PASSES - 1;
    end
    e = {sr, ld, 7'd0, en, ini, rnd, fin, bz, dv, PW'(pi)};
    a = {start_ready, cnt_ld, cnt_ld_data, cnt_en, core_init, round_en,
         core_final, busy, done_valid, pass_idx};
    check("outputs", 32'(a), 32'(e));
    if (rnd) check("round_index", 32'(cnt_value), 32'(pos - 1));
  endtask

  task automatic model_step(bit sv, bit dr, bit ab);
    if (m_k < 0) begin
      if (sv) m_k = 0;
    end else if (ab) m_k = -1;
    else if (m_k < TOTAL) m_k++;
    else if (dr) m_k = -1;
  endtask

  // Called at a falling edge: drive inputs, advance model, check next cycle.
  task automatic tick(bit sv, bit dr, bit ab);
    start_valid = sv;
    done_ready  = dr;
    abort       = ab;
    model_step(sv, dr, ab);
    @(negedge clk);
    if (m_chk) check_model();
  endtask

  typedef struct {
    int stall;     // cycles done_ready stays low after done_valid rises
    int abort_at;  // tick at which abort is raised, -1 for none
    bit hold;      // keep start_valid high for the whole job
    int exp_lat;   // ticks from acceptance to done_valid, -1 if aborted
    int exp_cnt;   // round index expected when abort is raised, -1 skip
  } vec_t;

  vec_t tbl[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int lat, len;
    bit ab, aborted;

    tbl[0] = '{0, -1,            0, LAT, -1};
    tbl[1] = '{5, -1,            0, LAT, -1};
    tbl[2] = '{0, PER + 1 + 31,  0, -1,  30};
    tbl[3] = '{0, -1,            0, LAT, -1};
    tbl[4] = '{2, -1,            1, LAT, -1};
    tbl[5] = '{0, 2,             0, -1,  0};

    rst = 1'b1; start_valid = 0; done_ready = 0; abort = 0;
    force_en = 0; force_val = 7'd0;
    m_k = -1; m_chk = 1;
    repeat (2) @(negedge clk);
    check_model();
    rst = 1'b0;
    repeat (8) tick(0, 0, 0);
    check_model();

    // Table-driven jobs: latency, stall, abort and held-start cases.
    for (int i = 0; i < 6; i++) begin
      tick(1, 0, 0);
      lat = 1; aborted = 0;
      while (!done_valid && !aborted && lat < 1000) begin
        ab = (lat == tbl[i].abort_at);
        if (ab && tbl[i].exp_cnt >= 0)
          check("cnt_at_abort", 32'(cnt_value), 32'(tbl[i].exp_cnt));
        tick(tbl[i].hold, 0, ab);
        if (ab) aborted = 1;
        else lat++;
      end
      check("done_latency", done_valid ? lat : -1, tbl[i].exp_lat);
      if (aborted) begin
        check("abort_busy", 32'(busy), 0);
        check("abort_pass", 32'(pass_idx), 0);
      end
      len = 0;
      while (done_valid && len < 1000) begin
        len++;
        tick(tbl[i].hold, len > tbl[i].stall, 0);
      end
      if (tbl[i].exp_lat > 0) check("done_len", len, tbl[i].stall + 1);
      check("idle_after", 32'(start_ready), 1);
      if (tbl[i].hold) begin
        tick(1, 0, 0);
        check("rearm_init", 32'(core_init), 1);
        tick(0, 0, 1);
      end
      tick(0, 0, 0);
    end

    // Asynchronous reset between edges in the middle of ROUND.
    tick(1, 0, 0);
    repeat (40) tick(0, 0, 0);
    check("pre_rst_round", 32'(round_en), 1);
    #2 rst = 1'b1;
    #1;
    m_k = -1;
    check_model();
    @(negedge clk);
    rst = 1'b0;
    check_model();
    repeat (150) tick(0, 1, 0);

    // Out-of-range round count forces an early FINAL; job still completes.
    tick(1, 0, 0);
    repeat (10) tick(0, 0, 0);
    check("force_pre_round", 32'(round_en), 1);
    m_chk = 0;
    force_val = 7'd100; force_en = 1;
    tick(0, 0, 0);
    check("force_final", 32'(core_final), 1);
    check("force_pass", 32'(pass_idx), 0);
    force_en = 0;
    lat = 0;
    while (!done_valid && lat < 500) begin
      tick(0, 0, 0);
      lat++;
    end
    check("force_done", 32'(done_valid), 1);
    check("force_done_lat", lat, PER + 1);
    tick(0, 1, 0);
    m_k = -1; m_chk = 1;
    check_model();

    // Randomised traffic against the reference model.
    repeat (6000)
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 149) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
